// File: rtl/wgen_mix_hls_deadlock_report_pkg.sv
// Shared types and helpers for the wgen_mix deadlock report filter.
package wgen_mix_deadlock_pkg;

  typedef enum logic [1:0] {
    DL_IDLE     = 2'd0,
    DL_WATCH    = 2'd1,
    DL_REPORTED = 2'd2
  } dl_state_t;

  localparam int TSTAMP_W = 32;

  // A programmed threshold of zero behaves exactly like a threshold of one.
  function automatic logic [TSTAMP_W-1:0] eff_thresh(input logic [TSTAMP_W-1:0] t);
    return (t == '0) ? TSTAMP_W'(1) : t;
  endfunction

endpackage

// File: rtl/wgen_mix_hls_deadlock_report_if.sv
// Bundle of monitor flags, threshold/acknowledge controls and the sticky report outputs.
interface wgen_mix_hls_deadlock_report_if #(
  parameter int NUM_MON  = 4,
  parameter int THRESH_W = 16,
  parameter int IDX_W    = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
);
  logic [NUM_MON-1:0]  block_in;
  logic [THRESH_W-1:0] thresh;
  logic                clear;
  logic                deadlock;
  logic                deadlock_pulse;
  logic [IDX_W-1:0]    deadlock_idx;
  logic [31:0]         deadlock_cycle;

  modport master (
    output block_in, thresh, clear,
    input  deadlock, deadlock_pulse, deadlock_idx, deadlock_cycle
  );

  modport slave (
    input  block_in, thresh, clear,
    output deadlock, deadlock_pulse, deadlock_idx, deadlock_cycle
  );
endinterface

// File: rtl/wgen_mix_hls_deadlock_report_prienc.sv
// Lowest-set-bit priority encoder: idx of the lowest asserted bit, any = at least one bit set.
module wgen_mix_deadlock_prienc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    any = |vec;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end
endmodule

// File: rtl/wgen_mix_hls_deadlock_report.sv
// Persistence filter over HLS deadlock monitor flags with a sticky, clearable report.
// Optional timestamp capture enabled by defining WGEN_MIX_DEADLOCK_TSTAMP_EN.
module wgen_mix_hls_deadlock_report
  import wgen_mix_deadlock_pkg::*;
#(
  parameter int NUM_MON  = 4,
  parameter int THRESH_W = 16,
  parameter int IDX_W    = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
  input  logic clock,
  input  logic reset,
  wgen_mix_hls_deadlock_report_if.slave bus
);
  dl_state_t           state_reg, state_next;
  logic [THRESH_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [IDX_W-1:0]    cand_reg, cand_next;
  logic [IDX_W-1:0]    idx_reg;
  logic                deadlock_reg, pulse_reg;
  logic                enter_report;
  logic [IDX_W-1:0]    pe_idx;
  logic                pe_any;
  logic [TSTAMP_W-1:0] thresh_eff;

  wgen_mix_deadlock_prienc #(.N(NUM_MON), .IW(IDX_W)) u_prienc (
    .vec (bus.block_in),
    .idx (pe_idx),
    .any (pe_any)
  );

  assign thresh_eff = eff_thresh(TSTAMP_W'(bus.thresh));
  assign cnt_inc    = (&cnt_reg) ? cnt_reg : cnt_reg + THRESH_W'(1);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cand_next    = cand_reg;
    enter_report = 1'b0;
    if (bus.clear) begin
      state_next = DL_IDLE;
      cnt_next   = '0;
      cand_next  = '0;
    end else begin
      unique case (state_reg)
        DL_IDLE: begin
          if (pe_any) begin
            cand_next = pe_idx;
            cnt_next  = THRESH_W'(1);
            if (thresh_eff == TSTAMP_W'(1)) begin
              state_next   = DL_REPORTED;
              enter_report = 1'b1;
            end else begin
              state_next = DL_WATCH;
            end
          end
        end
        DL_WATCH: begin
          if (!pe_any) begin
            state_next = DL_IDLE;
            cnt_next   = '0;
          end else if (pe_idx != cand_reg) begin
            // A different monitor became lowest: restart the persistence run.
            cand_next = pe_idx;
            cnt_next  = THRESH_W'(1);
          end else begin
            cnt_next = cnt_inc;
            if (TSTAMP_W'(cnt_inc) >= thresh_eff) begin
              state_next   = DL_REPORTED;
              enter_report = 1'b1;
            end
          end
        end
        DL_REPORTED: ;
        default: begin
          state_next = DL_IDLE;
          cnt_next   = '0;
          cand_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= DL_IDLE;
      cnt_reg      <= '0;
      cand_reg     <= '0;
      idx_reg      <= '0;
      deadlock_reg <= 1'b0;
      pulse_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      cand_reg     <= cand_next;
      deadlock_reg <= (state_next == DL_REPORTED);
      pulse_reg    <= enter_report;
      if (bus.clear)         idx_reg <= '0;
      else if (enter_report) idx_reg <= cand_next;
    end
  end

`ifdef WGEN_MIX_DEADLOCK_TSTAMP_EN
  logic [TSTAMP_W-1:0] cyc_reg;
  logic [TSTAMP_W-1:0] tstamp_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc_reg    <= '0;
      tstamp_reg <= '0;
    end else begin
      cyc_reg <= cyc_reg + TSTAMP_W'(1);
      if (bus.clear)         tstamp_reg <= '0;
      else if (enter_report) tstamp_reg <= cyc_reg;
    end
  end

  assign bus.deadlock_cycle = tstamp_reg;
`else
  assign bus.deadlock_cycle = '0;
`endif

  assign bus.deadlock       = deadlock_reg;
  assign bus.deadlock_pulse = pulse_reg;
  assign bus.deadlock_idx   = idx_reg;
endmodule

// File: tb/tb_wgen_mix_hls_deadlock_report.sv
// Randomized + directed bench for wgen_mix_hls_deadlock_report against a run-length reference model.
module tb_wgen_mix_hls_deadlock_report;
  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  wgen_mix_hls_deadlock_report_if #(.NUM_MON(4), .THRESH_W(16)) bus ();

  wgen_mix_hls_deadlock_report #(.NUM_MON(4), .THRESH_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: length of the current run of samples sharing the same lowest index.
  bit          m_rep;
  bit          m_pulse;
  int          m_len;
  int          m_idx;
  int          m_ridx;
  int unsigned m_tcyc;
  int unsigned edge_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return -1;
  endfunction

  function automatic int eff(input logic [15:0] t);
    return (t == 0) ? 1 : int'(t);
  endfunction

  function automatic logic [31:0] exp_cycle();
`ifdef WGEN_MIX_DEADLOCK_TSTAMP_EN
    return m_tcyc;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_rep = 0; m_pulse = 0; m_len = 0; m_idx = 0; m_ridx = 0; m_tcyc = 0; edge_cnt = 0;
  endtask

  task automatic step(input logic [3:0] b, input logic c);
    int lo;
    bus.block_in = b;
    bus.clear    = c;
    @(posedge clock);
    m_pulse = 0;
    if (c) begin
      m_rep = 0; m_len = 0; m_ridx = 0; m_tcyc = 0;
    end else if (!m_rep) begin
      if (b == 0) begin
        m_len = 0;
      end else begin
        lo = lowest(b);
        if (m_len > 0 && lo == m_idx) m_len++;
        else begin m_idx = lo; m_len = 1; end
        if (m_len >= eff(bus.thresh)) begin
          m_rep = 1; m_pulse = 1; m_ridx = m_idx; m_tcyc = edge_cnt;
        end
      end
    end
    edge_cnt++;
    @(negedge clock);
    $display("[TB] edge=%0d blk=%b clr=%b thr=%0d dl=%b pulse=%b idx=%0d cyc=%0d",
             edge_cnt, b, c, bus.thresh, bus.deadlock, bus.deadlock_pulse,
             bus.deadlock_idx, bus.deadlock_cycle);
    check("deadlock", 32'(bus.deadlock), 32'(m_rep));
    check("pulse", 32'(bus.deadlock_pulse), 32'(m_pulse));
    if (m_rep) check("idx", 32'(bus.deadlock_idx), 32'(m_ridx));
    check("cycle", bus.deadlock_cycle, exp_cycle());
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #2;
    check("rst_deadlock", 32'(bus.deadlock), 32'd0);
    check("rst_pulse", 32'(bus.deadlock_pulse), 32'd0);
    check("rst_idx", 32'(bus.deadlock_idx), 32'd0);
    check("rst_cycle", bus.deadlock_cycle, 32'd0);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] b;
    logic       c;
    bus.block_in = '0;
    bus.thresh   = 16'd3;
    bus.clear    = 1'b0;
    model_reset();
    #12;
    check("init_deadlock", 32'(bus.deadlock), 32'd0);
    check("init_cycle", bus.deadlock_cycle, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Three-cycle hold on monitor 2
    repeat (3) step(4'b0100, 1'b0);
    check("tp1_deadlock", 32'(bus.deadlock), 32'd1);
    check("tp1_idx", 32'(bus.deadlock_idx), 32'd2);
    check("tp1_pulse", 32'(bus.deadlock_pulse), 32'd1);
    step(4'b0100, 1'b0);
    check("tp1_pulse_once", 32'(bus.deadlock_pulse), 32'd0);
    step(4'b0000, 1'b1);

    // Gap in the run prevents a report
    repeat (2) step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    repeat (2) step(4'b0100, 1'b0);
    check("tp2_noreport", 32'(bus.deadlock), 32'd0);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b1);

    // Candidate switch restarts the count
    bus.thresh = 16'd4;
    repeat (2) step(4'b1000, 1'b0);
    repeat (3) step(4'b1010, 1'b0);
    check("tp3_early", 32'(bus.deadlock), 32'd0);
    step(4'b1010, 1'b0);
    check("tp3_deadlock", 32'(bus.deadlock), 32'd1);
    check("tp3_idx", 32'(bus.deadlock_idx), 32'd1);
    step(4'b0000, 1'b1);

    // Threshold 0 and clear colliding with a block sample
    bus.thresh = 16'd0;
    step(4'b0001, 1'b0);
    check("tp4_deadlock", 32'(bus.deadlock), 32'd1);
    check("tp4_idx", 32'(bus.deadlock_idx), 32'd0);
    step(4'b0001, 1'b1);
    check("tp4_cleared", 32'(bus.deadlock), 32'd0);
    step(4'b0000, 1'b0);
    check("tp4_norerep", 32'(bus.deadlock), 32'd0);
    step(4'b0001, 1'b0);
    check("tp4_rerep", 32'(bus.deadlock), 32'd1);
    step(4'b0000, 1'b1);

    // Asynchronous reset during WATCH
    bus.thresh = 16'd8;
    repeat (5) step(4'b0010, 1'b0);
    async_reset();
    bus.thresh = 16'd3;
    repeat (2) step(4'b0010, 1'b0);
    check("tp5_restart", 32'(bus.deadlock), 32'd0);
    step(4'b0010, 1'b0);
    check("tp5_report", 32'(bus.deadlock), 32'd1);

    // Timestamp of a report at cycles 10/11
    async_reset();
    repeat (10) step(4'b0000, 1'b0);
    bus.thresh = 16'd2;
    repeat (2) step(4'b0001, 1'b0);
`ifdef WGEN_MIX_DEADLOCK_TSTAMP_EN
    check("tp6_cycle", bus.deadlock_cycle, 32'd11);
`else
    check("tp6_cycle", bus.deadlock_cycle, 32'd0);
`endif
    step(4'b0000, 1'b1);

    // Randomized traffic; threshold changes only between runs
    b = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) b = 4'($urandom_range(0, 15));
      c = m_rep ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0);
      if (m_len == 0 && !m_rep && $urandom_range(0, 9) == 0)
        bus.thresh = 16'($urandom_range(0, 5));
      step(b, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wgen_mix_hls_deadlock_report.md
# wgen_mix_hls_deadlock_report

Consumes the per-instance `block` flags from the `wgen_mix` HLS deadlock index monitors and filters them: a deadlock is reported only after one monitor has held `block` for a programmable number of consecutive cycles. The block sits directly downstream of the monitors, at the top of the `wgen_mix` instance, and drives a sticky report that software or a debug probe reads and clears.

## Interface
- `NUM_MON`, 4: number of monitor `block` inputs, 1..32.
- `THRESH_W`, 16: width of the threshold and persistence counter.
- `IDX_W`, `$clog2(NUM_MON)` (minimum 1): width of the reported index.
- `clock` input 1: single clock for all logic.
- `reset` input 1: asynchronous, active-low; clears all state.
- `block_in` input NUM_MON: one `block` flag per monitor; bit i comes from the idx(i) monitor.
- `thresh` input THRESH_W: required consecutive-cycle count, quasi-static; 0 is treated as 1.
- `clear` input 1: synchronous single-cycle acknowledge; returns the block to IDLE.
- `deadlock` output 1: sticky report level.
- `deadlock_pulse` output 1: one-cycle strobe on report entry.
- `deadlock_idx` output IDX_W: index of the reporting monitor, valid while `deadlock`=1.
- `deadlock_cycle` output 32: cycle timestamp of the report (see Configuration).

## Operation
- Candidate: the lowest set bit of `block_in`, from a priority encoder.
- FSM states:
  - IDLE: `cnt`=0.
    - Any bit of `block_in` set: load `cand_idx`. With effective thresh=1 go to REPORTED; otherwise go to WATCH with `cnt`=1.
  - WATCH:
    - `block_in`==0: go to IDLE, `cnt`=0.
    - Lowest set bit ≠ `cand_idx`: reload `cand_idx`, `cnt`=1, stay in WATCH.
    - Otherwise: `cnt`+1. When `cnt`+1 ≥ effective thresh, go to REPORTED.
  - REPORTED:
    - `deadlock`=1, `deadlock_idx`=`cand_idx` frozen.
    - `block_in` is ignored.
    - Exit only on `clear`.
- `clear` has priority over every transition in every state. It forces IDLE, `cnt`=0, `cand_idx`=0. A `block_in` present in the same cycle is not sampled.
- `cnt` saturates at all-ones and never wraps.
- `thresh` changing during WATCH takes effect on the next compare. `cnt` is not reset.

## Timing
- Reset values: `deadlock`=0, `deadlock_pulse`=0, `deadlock_idx`=0, `deadlock_cycle`=0, state=IDLE, `cnt`=0.
- Latency: with effective thresh N, `deadlock` rises at the clock edge that takes the N-th consecutive same-index sample of `block_in`.
- `deadlock_pulse` is high for exactly the first cycle in which `deadlock` is high.
- `deadlock_idx` is registered together with `deadlock` and is stable until `clear`.
- After `clear` at edge k, `deadlock` is 0 from edge k. A new detection counts its first sample at edge k+1 at the earliest.
- Reset asserted mid-operation: all outputs return to reset values immediately, independent of the clock.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `WGEN_MIX_DEADLOCK_TSTAMP_EN` defined:
  - A free-running 32-bit cycle counter runs from reset. It wraps modulo 2^32.
  - Its value at the reporting edge is captured into `deadlock_cycle` and held until `clear`, which sets it to 0.
- Not defined: no counter is built and `deadlock_cycle` is tied to 0.

## Structure
- Package `wgen_mix_deadlock_pkg` holds:
  - the state enum (`DL_IDLE`, `DL_WATCH`, `DL_REPORTED`);
  - the timestamp width constant (32);
  - the effective-threshold function (0→1).
- One sub-module, `wgen_mix_deadlock_prienc`: a parameterised lowest-set-bit encoder that outputs `idx` and `any`.

## Test plan
- NUM_MON=4, thresh=3: hold `block_in`=4'b0100 for 3 cycles. Required: `deadlock`=1 and `deadlock_idx`=2 at the 3rd edge, `deadlock_pulse` high for exactly 1 cycle.
- thresh=3: `block_in`=0100 for 2 cycles, then 0000 for 1 cycle, then 0100 for 2 cycles. Required: no report, and state returns to IDLE.
- thresh=4: `block_in`=1000 for 2 cycles, then 1010 for 4 cycles. Required: the candidate switches to 1, `cnt` restarts at 1, and the report fires with `deadlock_idx`=1 at the 4th cycle of 1010.
- thresh=0: a single-cycle `block_in`=0001. Required: immediate report with `deadlock_idx`=0. Assert `clear` together with `block_in`=0001. Required: `deadlock`=0 next cycle and no re-report until a new sample after `clear`.
- Assert reset low while in WATCH with `cnt`=5. Required: all outputs 0 and IDLE at once; after release, counting restarts from 1.
- With `WGEN_MIX_DEADLOCK_TSTAMP_EN`, thresh=2, `block_in`=0001 starting at cycle 10. Required: `deadlock_cycle`=11. Without the macro, `deadlock_cycle`=0.
